instruction_fetch_unit: RTL and testbench

- IF stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and drives that register's PCAddResult and Instruction inputs.
- Owns the PC, runs a req/ack handshake to instruction memory with variable latency, and accepts branch/jump redirects from later stages.
- The IF/ID register has no enable, so this block holds its outputs stable during a Stall. It inserts NOP bubbles when no instruction is available.

---
 rtl/instruction_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS IF stage: PC, variable-latency imem handshake, redirect, stall hold
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemRdata,
    input  logic        IMemAck,
    output logic [31:0] PC,
    output logic [31:0] PCAddResult,
    output logic [31:0] Instruction,
    output logic        FetchValid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic [31:0] drain_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_pcadd;
    logic [31:0] pcadd_q;
    logic [31:0] instr_q;
    logic        valid_q;

    // Low two bits of a redirect target are dropped so fetches stay word aligned.
    assign redirect_pc = RedirectTarget & 32'hFFFF_FFFC;
    assign pc_plus4    = pc + 32'd4;

    assign PC          = pc;
    assign PCAddResult = pcadd_q;
    assign Instruction = instr_q;
    assign FetchValid  = valid_q;

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect outranks stall and ack handling.
    always_comb begin
        state_next = state;
        if (Redirect) begin
            case (state)
                FETCH:   state_next = IMemAck ? FETCH : DRAIN;
                HELD:    state_next = FETCH;
                DRAIN:   state_next = DRAIN;
                default: state_next = FETCH;
            endcase
        end else begin
            case (state)
                FETCH:   state_next = (IMemAck && Stall) ? HELD : FETCH;
                HELD:    state_next = Stall ? HELD : FETCH;
                DRAIN:   state_next = IMemAck ? FETCH : DRAIN;
                default: state_next = FETCH;
            endcase
        end
    end

    // Memory request outputs; DRAIN keeps presenting the abandoned address until its ack.
    always_comb begin
        IMemReq  = 1'b0;
        IMemAddr = pc;
        case (state)
            FETCH: begin
                IMemReq  = Reset_n;
                IMemAddr = pc;
            end
            DRAIN: begin
                IMemReq  = Reset_n;
                IMemAddr = drain_addr;
            end
            default: begin
                IMemReq  = 1'b0;
                IMemAddr = pc;
            end
        endcase
    end

    // PC, one-entry stall buffer and the IF/ID-facing output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc         <= RESET_PC;
            drain_addr <= 32'd0;
            buf_instr  <= 32'd0;
            buf_pcadd  <= 32'd0;
            pcadd_q    <= 32'd0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else if (Redirect) begin
            pc        <= redirect_pc;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            buf_instr <= 32'd0;
            buf_pcadd <= 32'd0;
            if (state == FETCH && !IMemAck) begin
                drain_addr <= pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (IMemAck) begin
                        pc <= pc_plus4;
                        if (Stall) begin
                            buf_instr <= IMemRdata;
                            buf_pcadd <= pc_plus4;
                        end else begin
                            instr_q <= IMemRdata;
                            pcadd_q <= pc_plus4;
                            valid_q <= 1'b1;
                        end
                    end else if (!Stall) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                HELD: begin
                    if (!Stall) begin
                        instr_q <= buf_instr;
                        pcadd_q <= buf_pcadd;
                        valid_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!Stall) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [3:0] M_REQ  = 4'b0001;
    localparam logic [3:0] M_ADDR = 4'b0010;
    localparam logic [3:0] M_PC   = 4'b0100;
    localparam logic [3:0] M_OUT  = 4'b1000;
    localparam logic [3:0] M_ALL  = 4'b1111;

    logic        Clk;
    logic        Reset_n;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        IMemAck;
    logic [31:0] PC;
    logic [31:0] PCAddResult;
    logic [31:0] Instruction;
    logic        FetchValid;

    typedef struct {
        int          id;
        logic [3:0]  mask;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcadd;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    instruction_fetch_unit dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .IMemReq        (IMemReq),
        .IMemAddr       (IMemAddr),
        .IMemRdata      (IMemRdata),
        .IMemAck        (IMemAck),
        .PC             (PC),
        .PCAddResult    (PCAddResult),
        .Instruction    (Instruction),
        .FetchValid     (FetchValid)
    );

    // Memory contents are a fixed function of the address.
    assign IMemRdata = IMemAddr ^ K;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input logic rstn, input logic stall, input logic redir,
                        input logic [31:0] tgt, input logic ack, input logic [3:0] mask,
                        input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                        input logic [31:0] e_instr, input logic [31:0] e_pcadd, input logic e_valid);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset_n        = rstn;
        Stall          = stall;
        Redirect       = redir;
        RedirectTarget = tgt;
        IMemAck        = ack;
        e.id    = cyc;
        e.mask  = mask;
        e.req   = e_req;
        e.addr  = e_addr;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.pcadd = e_pcadd;
        e.valid = e_valid;
        sb.push_back(e);
        cyc++;
    endtask

    // Monitor: every cycle with a pending expectation is checked on the falling edge.
    initial begin
        exp_t e;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mask[0]) begin
                    total++;
                    if (IMemReq !== e.req) begin
                        bad++;
                        $display("FAIL c%0d req got %0b want %0b", e.id, IMemReq, e.req);
                    end
                end
                if (e.mask[1]) begin
                    total++;
                    if (IMemAddr !== e.addr) begin
                        bad++;
                        $display("FAIL c%0d addr got %h want %h", e.id, IMemAddr, e.addr);
                    end
                end
                if (e.mask[2]) begin
                    total++;
                    if (PC !== e.pc) begin
                        bad++;
                        $display("FAIL c%0d pc got %h want %h", e.id, PC, e.pc);
                    end
                end
                if (e.mask[3]) begin
                    total++;
                    if (Instruction !== e.instr) begin
                        bad++;
                        $display("FAIL c%0d instr got %h want %h", e.id, Instruction, e.instr);
                    end
                    total++;
                    if (PCAddResult !== e.pcadd) begin
                        bad++;
                        $display("FAIL c%0d pcadd got %h want %h", e.id, PCAddResult, e.pcadd);
                    end
                    total++;
                    if (FetchValid !== e.valid) begin
                        bad++;
                        $display("FAIL c%0d valid got %0b want %0b", e.id, FetchValid, e.valid);
                    end
                end
            end
        end
    end

    initial begin
        Reset_n        = 1'b0;
        Stall          = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'd0;
        IMemAck        = 1'b1;

        //    rstn stall redir tgt            ack mask                  req addr          pc            instr          pcadd         valid
        // reset state
        step(0, 0, 0, 32'h0,          1, M_REQ|M_PC|M_OUT,     0, 32'h0,        32'h0,        NOP,           32'h0,        0);
        // zero-wait streaming from RESET_PC
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h0,        32'h0,        NOP,           32'h0,        0);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h4,        32'h4,        32'h0 ^ K,     32'h4,        1);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h8,        32'h8,        32'h4 ^ K,     32'h8,        1);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'hC,        32'hC,        32'h8 ^ K,     32'hC,        1);
        // two wait states at 0x10
        step(1, 0, 0, 32'h0,          0, M_ALL,                1, 32'h10,       32'h10,       32'hC ^ K,     32'h10,       1);
        step(1, 0, 0, 32'h0,          0, M_ALL,                1, 32'h10,       32'h10,       NOP,           32'h10,       0);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h10,       32'h10,       NOP,           32'h10,       0);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h14,       32'h14,       32'h10 ^ K,    32'h14,       1);
        // stall three cycles, ack on the first one
        step(1, 1, 0, 32'h0,          1, M_ALL,                1, 32'h18,       32'h18,       32'h14 ^ K,    32'h18,       1);
        step(1, 1, 0, 32'h0,          1, M_REQ|M_PC|M_OUT,     0, 32'h0,        32'h1C,       32'h14 ^ K,    32'h18,       1);
        step(1, 1, 0, 32'h0,          0, M_REQ|M_PC|M_OUT,     0, 32'h0,        32'h1C,       32'h14 ^ K,    32'h18,       1);
        step(1, 0, 0, 32'h0,          1, M_REQ|M_PC|M_OUT,     0, 32'h0,        32'h1C,       32'h14 ^ K,    32'h18,       1);
        step(1, 0, 0, 32'h0,          0, M_ALL,                1, 32'h1C,       32'h1C,       32'h18 ^ K,    32'h1C,       1);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h1C,       32'h1C,       NOP,           32'h1C,       0);
        // redirect to 0x103 while 0x20 is pending
        step(1, 0, 1, 32'h0000_0103,  0, M_ALL,                1, 32'h20,       32'h20,       32'h1C ^ K,    32'h20,       1);
        step(1, 0, 0, 32'h0,          0, M_ALL,                1, 32'h20,       32'h100,      NOP,           32'h20,       0);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h20,       32'h100,      NOP,           32'h20,       0);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h100,      32'h100,      NOP,           32'h20,       0);
        // redirect together with stall
        step(1, 1, 1, 32'h0000_0200,  0, M_ALL,                1, 32'h104,      32'h104,      32'h100 ^ K,   32'h104,      1);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h104,      32'h200,      NOP,           32'h104,      0);
        // redirect with ack in FETCH, to the top word, then wrap of PC+4
        step(1, 0, 1, 32'hFFFF_FFFF,  1, M_ALL,                1, 32'h200,      32'h200,      NOP,           32'h104,      0);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,         32'h104,      0);
        step(1, 0, 0, 32'h0,          0, M_ALL,                1, 32'h0,        32'h0,        32'h5A5A_FFFC, 32'h0,        1);
        // enter DRAIN, then pulse reset between clock edges
        step(1, 0, 1, 32'h0000_0300,  0, M_ALL,                1, 32'h0,        32'h0,        NOP,           32'h0,        0);
        step(1, 0, 0, 32'h0,          0, M_ALL,                1, 32'h0,        32'h300,      NOP,           32'h0,        0);
        step(0, 0, 0, 32'h0,          0, M_REQ|M_PC|M_OUT,     0, 32'h0,        32'h0,        NOP,           32'h0,        0);
        step(1, 0, 0, 32'h0,          1, M_ALL,                1, 32'h0,        32'h0,        NOP,           32'h0,        0);
        step(1, 0, 0, 32'h0,          0, M_ALL,                1, 32'h4,        32'h4,        32'h0 ^ K,     32'h4,        1);

        @(negedge Clk);
        @(negedge Clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_sb left %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
